// File: rtl/ahb_burst_arbiter.sv
// ahb_burst_arbiter
// Registered four-master AHB-Lite arbiter for the master-to-slave path of the
// bus matrix. It has programmable per-master priority, round-robin
// tie-breaking, burst-aware grant holding, HMASTLOCK support and optional
// starvation aging.
//
// Build option:
//   AHB_ARB_AGING_EN  when defined, per-master age counters are built. A
//                     requester that has waited AGE_MAX cycles is boosted
//                     above every programmed priority. When undefined,
//                     arbitration is strict priority with a round-robin
//                     tie-break, and AGE_MAX is not used.
//
// Ports:
//   HCLK         bus clock
//   HRESET       synchronous, active-high reset
//   M_HTRANS     {M3..M0} HTRANS, 2 bits per master
//   M_HBURST     {M3..M0} HBURST, 3 bits per master
//   M_HMASTLOCK  per-master lock request
//   M_Pri        {M3..M0} programmed priority; a higher value wins
//   HREADY       muxed slave HREADYOUT
//   gnt          one-hot address-phase owner
//   sel_a        binary encoding of gnt
//   sel_d        data-phase owner (follows sel_a on HREADY=1 edges)
//   mst_hready   HREADY routed to the address-phase and data-phase owners
//   busy         high whenever the FSM is not IDLE
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | parked on the last owner, no owner activity
// SINGLE | owner is doing SINGLE/INCR; held while the owner sends SEQ/BUSY
// BURST  | fixed-length burst; beat_cnt counts the remaining SEQ beats
// LOCK   | locked sequence; held until HMASTLOCK falls on an accepted beat
module ahb_burst_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int PRI_WIDTH = 2,
  parameter int AGE_MAX   = 15
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [2*NUM_MST-1:0]          M_HTRANS,
  input  logic [3*NUM_MST-1:0]          M_HBURST,
  input  logic [NUM_MST-1:0]            M_HMASTLOCK,
  input  logic [PRI_WIDTH*NUM_MST-1:0]  M_Pri,
  input  logic                          HREADY,
  output logic [NUM_MST-1:0]            gnt,
  output logic [1:0]                    sel_a,
  output logic [1:0]                    sel_d,
  output logic [NUM_MST-1:0]            mst_hready,
  output logic                          busy
);

  if (NUM_MST != 4) begin : g_bad_num_mst
    $error("ahb_burst_arbiter supports exactly 4 masters");
  end
  if (AGE_MAX < 1 || AGE_MAX > 255) begin : g_bad_age_max
    $error("ahb_burst_arbiter AGE_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // One extra bit so the aging boost (2^PRI_WIDTH) sits above every
  // programmable priority.
  localparam int EPW = PRI_WIDTH + 1;

  state_t               state_q, state_d;
  logic [NUM_MST-1:0]   gnt_q, gnt_d;
  logic [1:0]           sel_a_q, sel_a_d;
  logic [1:0]           sel_d_q;
  logic [3:0]           beat_q, beat_d;

  logic [NUM_MST-1:0]   req;
  logic [1:0]           own_trans;
  logic                 own_lock;
  logic [1:0]           rr_ptr;
  logic [EPW-1:0]       eff_pri [NUM_MST];
  logic                 win_found;
  logic [1:0]           win_idx;
  logic [EPW-1:0]       win_pri;
  logic [3:0]           win_len;
  logic                 arb_pt;

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      req[i] = (M_HTRANS[2*i +: 2] != TR_IDLE);
    end
  end

  assign own_trans = M_HTRANS[2*sel_a_q +: 2];
  assign own_lock  = M_HMASTLOCK[sel_a_q];
  assign rr_ptr    = sel_a_q + 2'd1;

`ifdef AHB_ARB_AGING_EN
  localparam int            AW      = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

  logic [AW-1:0] age_q [NUM_MST];

  // Counting continues through HREADY=0 stalls; a master that is (or is
  // about to become) the owner never accumulates age.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NUM_MST; i++) begin
      if (HRESET) begin
        age_q[i] <= '0;
      end else if (!req[i] || gnt_d[i]) begin
        age_q[i] <= '0;
      end else if (age_q[i] != AGE_LIM) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      eff_pri[i] = {1'b0, M_Pri[i*PRI_WIDTH +: PRI_WIDTH]};
      if (age_q[i] == AGE_LIM) begin
        eff_pri[i] = EPW'(1) << PRI_WIDTH;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      eff_pri[i] = {1'b0, M_Pri[i*PRI_WIDTH +: PRI_WIDTH]};
    end
  end
`endif

  // Scan in round-robin order starting after the previous owner; a strict
  // "greater than" keeps the earliest master on a priority tie.
  always_comb begin : p_winner
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = sel_a_q;
    win_pri   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = rr_ptr + 2'(k);
      if (req[cand] && (!win_found || (eff_pri[cand] > win_pri))) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_pri   = eff_pri[cand];
      end
    end
  end

  always_comb begin
    case (M_HBURST[3*win_idx +: 3])
      3'b010, 3'b011: win_len = 4'd3;
      3'b100, 3'b101: win_len = 4'd7;
      3'b110, 3'b111: win_len = 4'd15;
      default:        win_len = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_a_d = sel_a_q;
    beat_d  = beat_q;
    arb_pt  = 1'b0;
    if (HREADY) begin
      unique case (state_q)
        ST_IDLE:   arb_pt = 1'b1;
        ST_SINGLE: arb_pt = (own_trans == TR_IDLE) || (own_trans == TR_NONSEQ);
        // IDLE or NONSEQ from the owner mid-burst is an early termination.
        ST_BURST:  arb_pt = (own_trans == TR_IDLE) || (own_trans == TR_NONSEQ) ||
                            ((own_trans == TR_SEQ) && (beat_q == 4'd0));
        ST_LOCK:   arb_pt = !own_lock;
        default:   arb_pt = 1'b0;
      endcase

      if (arb_pt) begin
        if (win_found) begin
          gnt_d   = NUM_MST'(1) << win_idx;
          sel_a_d = win_idx;
          if (M_HMASTLOCK[win_idx]) begin
            state_d = ST_LOCK;
            beat_d  = 4'd0;
          end else if (win_len != 4'd0) begin
            state_d = ST_BURST;
            beat_d  = win_len;
          end else begin
            state_d = ST_SINGLE;
            beat_d  = 4'd0;
          end
        end else begin
          // Nobody asking: stay parked on the current owner.
          state_d = ST_IDLE;
          beat_d  = 4'd0;
        end
      end else if ((state_q == ST_BURST) && (own_trans == TR_SEQ)) begin
        beat_d = beat_q - 4'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= NUM_MST'(1);
      sel_a_q <= 2'd0;
      sel_d_q <= 2'd0;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_a_q <= sel_a_d;
      beat_q  <= beat_d;
      if (HREADY) begin
        sel_d_q <= sel_a_q;
      end
    end
  end

  assign gnt        = gnt_q;
  assign sel_a      = sel_a_q;
  assign sel_d      = sel_d_q;
  assign busy       = (state_q != ST_IDLE);
  assign mst_hready = {NUM_MST{HREADY}} & (gnt_q | (NUM_MST'(1) << sel_d_q));

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
module tb_ahb_burst_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [7:0]  M_HTRANS;
  logic [11:0] M_HBURST;
  logic [3:0]  M_HMASTLOCK;
  logic [7:0]  M_Pri;
  logic        HREADY;
  logic [3:0]  gnt;
  logic [1:0]  sel_a;
  logic [1:0]  sel_d;
  logic [3:0]  mst_hready;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_burst_arbiter #(
    .NUM_MST   (4),
    .PRI_WIDTH (2),
    .AGE_MAX   (4)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .M_HTRANS    (M_HTRANS),
    .M_HBURST    (M_HBURST),
    .M_HMASTLOCK (M_HMASTLOCK),
    .M_Pri       (M_Pri),
    .HREADY      (HREADY),
    .gnt         (gnt),
    .sel_a       (sel_a),
    .sel_d       (sel_d),
    .mst_hready  (mst_hready),
    .busy        (busy)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic [1:0] tr, input logic [2:0] hb, input logic lk);
    M_HTRANS[2*m +: 2] = tr;
    M_HBURST[3*m +: 3] = hb;
    M_HMASTLOCK[m]     = lk;
  endtask

  task automatic all_idle();
    M_HTRANS    = '0;
    M_HBURST    = '0;
    M_HMASTLOCK = '0;
  endtask

  initial begin
    logic [1:0] pat [10];
    pat = '{SQ, SQ, BSY, SQ, SQ, BSY, SQ, SQ, SQ, SQ};

    HRESET = 1'b1;
    HREADY = 1'b1;
    M_Pri  = '0;
    all_idle();
    step();
    step();
    chk("rst_gnt",        32'(gnt),        32'h1);
    chk("rst_sel_a",      32'(sel_a),      32'h0);
    chk("rst_sel_d",      32'(sel_d),      32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_mst_hready", 32'(mst_hready), 32'h1);

    // M1 single transfer, all priorities zero
    HRESET = 1'b0;
    set_m(1, NSQ, 3'b000, 1'b0);
    step();
    chk("single_gnt",        32'(gnt),        32'h2);
    chk("single_sel_a",      32'(sel_a),      32'h1);
    chk("single_sel_d_lag",  32'(sel_d),      32'h0);
    chk("single_busy",       32'(busy),       32'h1);
    chk("single_mst_hready", 32'(mst_hready), 32'h3);
    set_m(1, IDL, 3'b000, 1'b0);
    step();
    chk("park_gnt",   32'(gnt),   32'h2);
    chk("park_sel_d", 32'(sel_d), 32'h1);
    chk("park_busy",  32'(busy),  32'h0);

    // Round robin among M0, M1, M3 at equal priority, previous owner M1
    M_Pri = 8'h45;
    set_m(0, NSQ, 3'b000, 1'b0);
    set_m(1, NSQ, 3'b000, 1'b0);
    set_m(3, NSQ, 3'b000, 1'b0);
    step();
    chk("rr_1st_m3", 32'(gnt), 32'h8);
    step();
    chk("rr_2nd_m0", 32'(gnt), 32'h1);
    step();
    chk("rr_3rd_m1", 32'(gnt), 32'h2);
    step();
    chk("rr_4th_m3", 32'(gnt), 32'h8);
    chk("rr_sel_a",  32'(sel_a), 32'h3);
    all_idle();
    step();
    chk("rr_idle_busy", 32'(busy), 32'h0);

    // M0 INCR8 with two BUSY beats while M2 (same priority) waits
    M_Pri = 8'h33;
    set_m(0, NSQ, 3'b101, 1'b0);
    step();
    chk("burst_gnt_m0", 32'(gnt),  32'h1);
    chk("burst_busy",   32'(busy), 32'h1);
    set_m(2, NSQ, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      set_m(0, pat[i], 3'b101, 1'b0);
      step();
      if (i < 9) chk("burst_hold", 32'(gnt), 32'h1);
      else       chk("burst_handover_m2", 32'(gnt), 32'h4);
    end
    chk("burst_sel_a", 32'(sel_a), 32'h2);

    // M1 INCR4 ends while HREADY is held low and M3 waits
    all_idle();
    set_m(1, NSQ, 3'b011, 1'b0);
    step();
    chk("stall_gnt_m1", 32'(gnt), 32'h2);
    set_m(1, SQ,  3'b011, 1'b0);
    set_m(3, NSQ, 3'b000, 1'b0);
    step();
    step();
    step();
    chk("stall_pre_sel_d", 32'(sel_d), 32'h1);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_gnt_held",   32'(gnt),   32'h2);
      chk("stall_sel_d_held", 32'(sel_d), 32'h1);
    end
    chk("stall_mst_hready", 32'(mst_hready), 32'h0);
    HREADY = 1'b1;
    step();
    chk("stall_handover_m3", 32'(gnt),   32'h8);
    chk("stall_sel_d_lag",   32'(sel_d), 32'h1);
    all_idle();
    step();
    chk("stall_sel_d_m3", 32'(sel_d), 32'h3);

    // M3 locked sequence of 5 transfers while M0 has top priority
    M_Pri = 8'h03;
    set_m(3, NSQ, 3'b000, 1'b1);
    step();
    chk("lock_gnt_m3", 32'(gnt), 32'h8);
    set_m(0, NSQ, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_hold", 32'(gnt), 32'h8);
    end
    set_m(3, NSQ, 3'b000, 1'b0);
    step();
    chk("lock_release_m0", 32'(gnt), 32'h1);

    // M0 at priority 0 competing with back-to-back M1 singles at priority 3
    all_idle();
    M_Pri = 8'h0C;
    set_m(1, NSQ, 3'b000, 1'b0);
    step();
    chk("age_gnt_m1", 32'(gnt), 32'h2);
    set_m(0, NSQ, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("age_wait", 32'(gnt), 32'h2);
    end
    step();
`ifdef AHB_ARB_AGING_EN
    chk("age_boost_m0", 32'(gnt), 32'h1);
`else
    chk("age_strict_m1", 32'(gnt), 32'h2);
`endif
    step();
    chk("age_after", 32'(gnt), 32'h2);

    // Reset in the middle of an INCR16 burst
    all_idle();
    set_m(1, NSQ, 3'b111, 1'b0);
    step();
    chk("rst_burst_gnt", 32'(gnt), 32'h2);
    set_m(1, SQ, 3'b111, 1'b0);
    step();
    step();
    HRESET = 1'b1;
    step();
    chk("midrst_gnt",   32'(gnt),   32'h1);
    chk("midrst_sel_a", 32'(sel_a), 32'h0);
    chk("midrst_sel_d", 32'(sel_d), 32'h0);
    chk("midrst_busy",  32'(busy),  32'h0);
    HRESET = 1'b0;
    all_idle();
    step();
    chk("postrst_busy", 32'(busy), 32'h0);
    chk("postrst_gnt",  32'(gnt),  32'h1);
    set_m(2, NSQ, 3'b011, 1'b0);
    step();
    chk("postrst_gnt_m2", 32'(gnt),  32'h4);
    chk("postrst_busy2",  32'(busy), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
